// File: rtl/execute_stage_pkg.sv
// Shared types for the execute stage: the control bundle carried down the pipeline.
package execute_stage_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] wb_sel;
  } control_type;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX operand bus into the execute stage and EX/MEM register contents out of it.
interface execute_stage_if;
  import execute_stage_pkg::*;

  logic        in_valid;
  logic        flush;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] imm;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic        muldiv;
  logic        mem_write_in;
  logic        mem_read_in;
  control_type control_in;
  logic [4:0]  rd_in;

  logic [31:0] alu_result;
  logic        MemWrite;
  logic        MemRead;
  control_type control_out;
  logic [4:0]  rd_out;
  logic        out_valid;
  logic        stall;

  modport master (
    output in_valid, flush, data1, data2, imm, alu_src, alu_op, muldiv,
           mem_write_in, mem_read_in, control_in, rd_in,
    input  alu_result, MemWrite, MemRead, control_out, rd_out, out_valid, stall
  );

  modport slave (
    input  in_valid, flush, data1, data2, imm, alu_src, alu_op, muldiv,
           mem_write_in, mem_read_in, control_in, rd_in,
    output alu_result, MemWrite, MemRead, control_out, rd_out, out_valid, stall
  );

endinterface

// File: rtl/execute_stage.sv
// RV32IM execute stage: single-cycle ALU/MUL into the EX/MEM register, plus an
// iterative radix-2 restoring divider that holds off upstream while it runs.
module execute_stage
  import execute_stage_pkg::*;
(
  input logic           clk,
  input logic           rst,
  execute_stage_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned PROD_W = 2 * XLEN;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [XLEN-1:0]  dvs_q, dvs_n, quot_q, quot_n, rem_q, rem_n;
  logic             q_neg_q, q_neg_n, r_neg_q, r_neg_n;
  logic             dz_q, dz_n, sel_rem_q, sel_rem_n;
  logic [4:0]       p_rd_q, p_rd_n;
  control_type      p_ctrl_q, p_ctrl_n;
  logic             p_mw_q, p_mw_n, p_mr_q, p_mr_n;

  logic [XLEN-1:0]  res_q, res_n;
  logic             mw_q, mw_n, mr_q, mr_n;
  control_type      ctrl_q, ctrl_n;
  logic [4:0]       rd_q, rd_n;
  logic             vld_q, vld_n, stall_q, stall_n;

  logic [2:0]        f3;
  logic [XLEN-1:0]   op_b, alu_res, mul_res;
  logic signed [XLEN:0] mul_a, mul_b;
  logic [PROD_W-1:0] prod;
  logic              is_div, div_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, q_fin, r_fin;
  logic [XLEN:0]     rem_sh, diff;

  // Combinational ALU, 33x33 signed multiplier and divider datapath
  always_comb begin
    f3   = bus.alu_op[2:0];
    op_b = bus.alu_src ? bus.imm : bus.data2;
    case (bus.alu_op)
      4'd0:    alu_res = bus.data1 + op_b;
      4'd1:    alu_res = bus.data1 - op_b;
      4'd2:    alu_res = bus.data1 << op_b[4:0];
      4'd3:    alu_res = {31'd0, $signed(bus.data1) < $signed(op_b)};
      4'd4:    alu_res = {31'd0, bus.data1 < op_b};
      4'd5:    alu_res = bus.data1 ^ op_b;
      4'd6:    alu_res = bus.data1 >> op_b[4:0];
      4'd7:    alu_res = $unsigned($signed(bus.data1) >>> op_b[4:0]);
      4'd8:    alu_res = bus.data1 | op_b;
      4'd9:    alu_res = bus.data1 & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase

    // rs1 is signed except for MULHU; rs2 is signed only for MUL/MULH
    mul_a   = {(f3 != 3'd3) & bus.data1[31], bus.data1};
    mul_b   = {~f3[1] & bus.data2[31], bus.data2};
    prod    = PROD_W'(mul_a) * PROD_W'(mul_b);
    mul_res = (f3 == 3'd0) ? prod[XLEN-1:0] : prod[PROD_W-1:XLEN];

    is_div     = bus.muldiv & f3[2];
    div_signed = ~f3[0];
    a_neg      = div_signed & bus.data1[31];
    b_neg      = div_signed & bus.data2[31];
    a_mag      = a_neg ? -bus.data1 : bus.data1;
    b_mag      = b_neg ? -bus.data2 : bus.data2;

    rem_sh = {rem_q, quot_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};

    // Divide-by-zero quotient is forced; remainder sign fix already yields data1
    q_fin = dz_q ? '1 : (q_neg_q ? -quot_q : quot_q);
    r_fin = r_neg_q ? -rem_q : rem_q;
  end

  // Next-state and next-output logic; every path loads a bubble unless it writes
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    dvs_n     = dvs_q;
    quot_n    = quot_q;
    rem_n     = rem_q;
    q_neg_n   = q_neg_q;
    r_neg_n   = r_neg_q;
    dz_n      = dz_q;
    sel_rem_n = sel_rem_q;
    p_rd_n    = p_rd_q;
    p_ctrl_n  = p_ctrl_q;
    p_mw_n    = p_mw_q;
    p_mr_n    = p_mr_q;
    res_n     = '0;
    mw_n      = 1'b0;
    mr_n      = 1'b0;
    ctrl_n    = '0;
    rd_n      = '0;
    vld_n     = 1'b0;

    if (bus.flush) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_div) begin
              state_n   = DIV;
              cnt_n     = '0;
              dvs_n     = b_mag;
              quot_n    = a_mag;
              rem_n     = '0;
              q_neg_n   = a_neg ^ b_neg;
              r_neg_n   = a_neg;
              dz_n      = (bus.data2 == '0);
              sel_rem_n = f3[1];
              p_rd_n    = bus.rd_in;
              p_ctrl_n  = bus.control_in;
              p_mw_n    = bus.mem_write_in;
              p_mr_n    = bus.mem_read_in;
            end else begin
              res_n  = bus.muldiv ? mul_res : alu_res;
              mw_n   = bus.mem_write_in;
              mr_n   = bus.mem_read_in;
              ctrl_n = bus.control_in;
              rd_n   = bus.rd_in;
              vld_n  = 1'b1;
            end
          end
        end
        DIV: begin
          quot_n = {quot_q[XLEN-2:0], ~diff[XLEN]};
          rem_n  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          cnt_n  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) state_n = FIN;
        end
        FIN: begin
          res_n   = sel_rem_q ? r_fin : q_fin;
          mw_n    = p_mw_q;
          mr_n    = p_mr_q;
          ctrl_n  = p_ctrl_q;
          rd_n    = p_rd_q;
          vld_n   = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    stall_n = (state_n != IDLE);
  end

  // State and EX/MEM register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvs_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      sel_rem_q <= 1'b0;
      p_rd_q    <= '0;
      p_ctrl_q  <= '0;
      p_mw_q    <= 1'b0;
      p_mr_q    <= 1'b0;
      res_q     <= '0;
      mw_q      <= 1'b0;
      mr_q      <= 1'b0;
      ctrl_q    <= '0;
      rd_q      <= '0;
      vld_q     <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      dvs_q     <= dvs_n;
      quot_q    <= quot_n;
      rem_q     <= rem_n;
      q_neg_q   <= q_neg_n;
      r_neg_q   <= r_neg_n;
      dz_q      <= dz_n;
      sel_rem_q <= sel_rem_n;
      p_rd_q    <= p_rd_n;
      p_ctrl_q  <= p_ctrl_n;
      p_mw_q    <= p_mw_n;
      p_mr_q    <= p_mr_n;
      res_q     <= res_n;
      mw_q      <= mw_n;
      mr_q      <= mr_n;
      ctrl_q    <= ctrl_n;
      rd_q      <= rd_n;
      vld_q     <= vld_n;
      stall_q   <= stall_n;
    end
  end

  assign bus.alu_result  = res_q;
  assign bus.MemWrite    = mw_q;
  assign bus.MemRead     = mr_q;
  assign bus.control_out = ctrl_q;
  assign bus.rd_out      = rd_q;
  assign bus.out_valid   = vld_q;
  assign bus.stall       = stall_q;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized scoreboard bench for execute_stage: the driver queues expected
// EX/MEM contents and the cycle they must appear; a negedge monitor checks them.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  execute_stage_if bus();

  execute_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [10:0] fields;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the ISA definitions, using wide integers
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] im, input logic src,
                                        input logic [3:0] op, input logic md);
    logic [31:0]     ob;
    longint          sa, sb, sob;
    longint unsigned ua, ub;
    logic [63:0]     p;
    ob  = src ? im : b;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sob = longint'($signed(ob));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    if (!md) begin
      case (op)
        4'd0:    return a + ob;
        4'd1:    return a - ob;
        4'd2:    return a << ob[4:0];
        4'd3:    return (sa < sob) ? 32'd1 : 32'd0;
        4'd4:    return (a < ob) ? 32'd1 : 32'd0;
        4'd5:    return a ^ ob;
        4'd6:    return a >> ob[4:0];
        4'd7:    return 32'(sa >>> ob[4:0]);
        4'd8:    return a | ob;
        4'd9:    return a & ob;
        4'd10:   return ob;
        default: return 32'd0;
      endcase
    end
    case (op[2:0])
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Drive one instruction, hold it while stalled, queue its expected result
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                      input logic src, input logic [3:0] op, input logic md,
                      input logic mw, input logic mr, input logic [3:0] c,
                      input logic [4:0] rd, input bit push);
    exp_t e;
    int   guard = 0;
    bus.data1 = a; bus.data2 = b; bus.imm = im; bus.alu_src = src;
    bus.alu_op = op; bus.muldiv = md; bus.mem_write_in = mw; bus.mem_read_in = mr;
    bus.control_in = c; bus.rd_in = rd; bus.in_valid = 1'b1;
    while (bus.stall && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (bus.stall) begin
      tests++; fails++;
      $display("FAIL stall_timeout: stall still 1 after %0d cycles, required 0", guard);
    end else if (push) begin
      e.res    = model(a, b, im, src, op, md);
      e.fields = {rd, mw, mr, c};
      e.cyc    = cyc + 1 + ((md && op[2]) ? 33 : 0);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (sb_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: valid outputs pop the scoreboard, everything else must be a bubble
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: out_valid 1 with result 0x%08h, required no result",
                   bus.alu_result);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", bus.alu_result, e.res);
          chk("fields", 32'({bus.rd_out, bus.MemWrite, bus.MemRead, bus.control_out}),
              32'(e.fields));
          chk("latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("bubble_result", bus.alu_result, 32'd0);
        chk("bubble_fields", 32'({bus.rd_out, bus.MemWrite, bus.MemRead, bus.control_out}),
            32'd0);
      end
    end
  end

  initial begin
    int n;
    logic        md;
    logic [3:0]  op;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.flush = 1'b0;
    bus.data1 = 32'd1; bus.data2 = 32'd2; bus.imm = 32'd3; bus.alu_src = 1'b0;
    bus.alu_op = 4'd0; bus.muldiv = 1'b0; bus.mem_write_in = 1'b1; bus.mem_read_in = 1'b1;
    bus.control_in = 4'hF; bus.rd_in = 5'd9;

    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_result", bus.alu_result, 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // Directed ALU and MUL cases, back to back
    send(32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'h5, 5'd7, 1'b1);
    send(32'h8000_0000, 32'd0, 32'd4, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'h1, 5'd8, 1'b1);
    send(32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 4'h2, 5'd9, 1'b1);
    for (int f = 0; f < 4; f++)
      send(32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 4'(f), 1'b1, 1'b0, 1'b0, 4'(f), 5'(10 + f), 1'b1);

    // DIV -7/2 with stall-length measurement
    send(32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 4'h3, 5'd3, 1'b1);
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("div_stall_cycles", 32'(n), 32'd33);

    // REM -7/2 followed by an ADD held during the stall
    send(32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 4'h4, 5'd4, 1'b1);
    send(32'd20, 32'd22, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'h6, 5'd5, 1'b1);

    // Division corners
    send(32'd10, 32'd0, 32'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'h7, 5'd11, 1'b1);
    send(32'd10, 32'd0, 32'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 4'h8, 5'd12, 1'b1);
    send(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 4'h9, 5'd13, 1'b1);
    send(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 4'hA, 5'd14, 1'b1);
    send(32'hFFFF_FFF0, 32'd0, 32'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 4'hB, 5'd15, 1'b1);
    drain();

    // Flush at E10 of a division: no result, stall drops next cycle
    send(32'd100, 32'd7, 32'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 4'h1, 5'd1, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_div_stall", 32'(bus.stall), 32'd0);
    repeat (40) begin @(posedge clk); #1; end

    // Flush with a same-cycle single-cycle op
    bus.data1 = 32'd1; bus.data2 = 32'd1; bus.alu_op = 4'd0; bus.muldiv = 1'b0;
    bus.rd_in = 5'd2; bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_op_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a division
    send(32'd55, 32'd5, 32'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'h2, 5'd6, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_div_stall", 32'(bus.stall), 32'd0);
    repeat (40) begin @(posedge clk); #1; end

    // Randomized mix
    for (int i = 0; i < 200; i++) begin
      md = ($urandom_range(0, 3) == 0);
      op = md ? {1'b0, 3'($urandom_range(0, 7))} : 4'($urandom_range(0, 15));
      send(pick32(), pick32(), pick32(), 1'($urandom_range(0, 1)), op, md,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           5'($urandom_range(0, 31)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
